// File: rtl/concat_pkg.sv
// Shared widths and FSM state type for the bit-field concatenation packer.
package concat_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned LEN_W  = 6;
   localparam int unsigned BUF_W  = 2 * DATA_W;

   typedef enum logic [0:0] {ACCUM, EMIT} state_e;

endpackage

// File: rtl/concat_packer_if.sv
// Field-in / word-out handshake bundle for concat_packer.
interface concat_packer_if #(
   parameter int unsigned DATA_W = concat_pkg::DATA_W,
   parameter int unsigned LEN_W  = concat_pkg::LEN_W
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [LEN_W-1:0]  in_len;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [LEN_W-1:0]  out_fill;

   modport master (
      output in_valid, in_data, in_len, flush, out_ready,
      input  in_ready, out_valid, out_data, out_fill
   );

   modport slave (
      input  in_valid, in_data, in_len, flush, out_ready,
      output in_ready, out_valid, out_data, out_fill
   );

endinterface

// File: rtl/field_aligner.sv
// Masks a right-aligned field to its length and shifts it to sit just below the
// cnt bits already held in the MSB-first buffer.
module field_aligner #(
   parameter int unsigned DATA_W = concat_pkg::DATA_W,
   parameter int unsigned LEN_W  = concat_pkg::LEN_W
) (
   input  logic [DATA_W-1:0]   data,
   input  logic [LEN_W-1:0]    len,
   input  logic [LEN_W:0]      cnt,
   output logic [2*DATA_W-1:0] field,
   output logic [LEN_W:0]      new_cnt
);

   localparam int unsigned BUF_W = 2 * DATA_W;
   localparam int unsigned CNT_W = LEN_W + 1;

   // 33 bits wide so that len == DATA_W does not overflow the mask.
   logic [DATA_W:0]    one;
   logic [DATA_W:0]    mask;
   logic [BUF_W-1:0]   masked;
   logic [CNT_W-1:0]   shamt;

   always_comb begin
      one     = {{DATA_W{1'b0}}, 1'b1};
      mask    = (one << len) - one;
      masked  = {{(BUF_W-DATA_W-1){1'b0}}, {1'b0, data} & mask};
      shamt   = CNT_W'(BUF_W) - cnt - CNT_W'(len);
      field   = masked << shamt;
      new_cnt = cnt + CNT_W'(len);
   end

endmodule

// File: rtl/concat_packer.sv
// Packs 1..DATA_W-bit fields MSB-first into DATA_W-bit words; flush emits the
// left-aligned partial word with its fill count.
module concat_packer #(
   parameter int unsigned DATA_W = concat_pkg::DATA_W,
   parameter int unsigned LEN_W  = concat_pkg::LEN_W
) (
   input logic            clk,
   input logic            rst_n,
   concat_packer_if.slave bus
);

   import concat_pkg::*;

   localparam int unsigned BW    = 2 * DATA_W;
   localparam int unsigned CNT_W = LEN_W + 1;

   state_e            state_q, state_d;
   logic [BW-1:0]     buf_q, buf_d, field;
   logic [CNT_W-1:0]  cnt_q, cnt_d, new_cnt;
   logic              flush_pend_q, flush_pend_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [LEN_W-1:0]  out_fill_q, out_fill_d;
   logic [LEN_W-1:0]  len_c;
   logic              in_ready, accept;

   assign len_c = (bus.in_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : bus.in_len;

   field_aligner #(
      .DATA_W(DATA_W),
      .LEN_W (LEN_W)
   ) u_aligner (
      .data   (bus.in_data),
      .len    (len_c),
      .cnt    (cnt_q),
      .field  (field),
      .new_cnt(new_cnt)
   );

   assign in_ready      = (state_q == ACCUM) && (cnt_q < CNT_W'(DATA_W)) && !flush_pend_q;
   assign accept        = bus.in_valid && in_ready;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == EMIT);
   assign bus.out_data  = out_data_q;
   assign bus.out_fill  = out_fill_q;

   always_comb begin
      state_d      = state_q;
      buf_d        = buf_q;
      cnt_d        = cnt_q;
      flush_pend_d = flush_pend_q | bus.flush;
      out_data_d   = out_data_q;
      out_fill_d   = out_fill_q;
      unique case (state_q)
         ACCUM: begin
            if (accept) begin
               buf_d = buf_q | field;
               cnt_d = new_cnt;
               if (new_cnt >= CNT_W'(DATA_W)) begin
                  state_d    = EMIT;
                  out_data_d = buf_d[BW-1 -: DATA_W];
                  out_fill_d = LEN_W'(DATA_W);
               end
            end else if (flush_pend_q) begin
               // An empty buffer retires the flush without producing a word.
               if (cnt_q != '0) begin
                  state_d    = EMIT;
                  out_data_d = buf_q[BW-1 -: DATA_W];
                  out_fill_d = cnt_q[LEN_W-1:0];
               end
               flush_pend_d = bus.flush;
            end
         end
         EMIT: begin
            // A partial word drains to an all-zero buffer under the same shift.
            if (bus.out_ready) begin
               buf_d   = buf_q << DATA_W;
               cnt_d   = cnt_q - CNT_W'(out_fill_q);
               state_d = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ACCUM;
         buf_q        <= '0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
         out_data_q   <= '0;
         out_fill_q   <= '0;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
         out_data_q   <= out_data_d;
         out_fill_q   <= out_fill_d;
      end
   end

endmodule

// File: tb/tb_concat_packer.sv
// Directed bench for concat_packer: a bit-queue model predicts every emitted
// word, and literal expectations pin the model for each scenario.
module tb_concat_packer;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   bit          bits_q[$];
   logic [37:0] exp_q[$];
   logic [37:0] got_q[$];

   concat_packer_if #(.DATA_W(32), .LEN_W(6)) bus ();

   concat_packer #(
      .DATA_W(32),
      .LEN_W (6)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_accept(input logic [31:0] d, input logic [5:0] l);
      int          n;
      logic [31:0] w;
      n = (l > 6'd32) ? 32 : int'(l);
      for (int i = n - 1; i >= 0; i--) bits_q.push_back(d[i]);
      while (bits_q.size() >= 32) begin
         for (int i = 31; i >= 0; i--) w[i] = bits_q.pop_front();
         exp_q.push_back({w, 6'd32});
      end
   endfunction

   function automatic void model_flush();
      int          n;
      logic [31:0] w;
      n = bits_q.size();
      w = '0;
      if (n > 0) begin
         for (int i = 0; i < n; i++) w[31-i] = bits_q[i];
         exp_q.push_back({w, 6'(n)});
         bits_q.delete();
      end
   endfunction

   // Sampled at negedge: the values seen here are what the next rising edge acts on.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bits_q.delete();
         exp_q.delete();
      end else begin
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               chk("no_spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
               chk("out_data", 64'(bus.out_data), 64'(exp_q[0][37:6]));
               chk("out_fill", 64'(bus.out_fill), 64'(exp_q[0][5:0]));
               if (bus.out_ready) begin
                  got_q.push_back({bus.out_data, bus.out_fill});
                  void'(exp_q.pop_front());
               end
            end
         end
         if (bus.in_valid && bus.in_ready) model_accept(bus.in_data, bus.in_len);
         if (bus.flush) model_flush();
      end
   end

   // Drivers start and end 1 time unit after a rising edge.
   task automatic send(input logic [31:0] d, input logic [5:0] l, input bit fl);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_len   = l;
      bus.flush    = fl;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(posedge clk);
         #1 bus.flush = 1'b0;
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
   endtask

   task automatic do_flush();
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || bus.out_valid) && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic pop_got(input string name, input logic [31:0] d, input logic [5:0] f);
      logic [37:0] g;
      if (got_q.size() == 0) begin
         chk({name, "_present"}, 64'(got_q.size()), 64'd1);
      end else begin
         g = got_q.pop_front();
         chk({name, "_data"}, 64'(g[37:6]), 64'(d));
         chk({name, "_fill"}, 64'(g[5:0]), 64'(f));
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_len    = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b1;
      #1 rst_n      = 1'b0;
      #2;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data",  64'(bus.out_data),  64'd0);
      chk("rst_out_fill",  64'(bus.out_fill),  64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(3);
      chk("post_rst_idle", 64'(bus.out_valid), 64'd0);

      // Four bytes make one full word.
      send(32'hAA, 6'd8, 1'b0);
      send(32'hBB, 6'd8, 1'b0);
      send(32'hCC, 6'd8, 1'b0);
      send(32'hDD, 6'd8, 1'b0);
      drain("full");
      pop_got("full", 32'hAABBCCDD, 6'd32);

      // Partial flush, then a flush of an empty buffer.
      send(32'h0, 6'd3, 1'b0);
      send(32'h2, 6'd4, 1'b0);
      send(32'h3, 6'd2, 1'b0);
      do_flush();
      drain("partial");
      pop_got("partial", 32'h05800000, 6'd9);
      do_flush();
      idle(4);
      chk("empty_flush_valid", 64'(bus.out_valid), 64'd0);
      chk("empty_flush_words", 64'(got_q.size()), 64'd0);

      // Field straddling the word boundary.
      send(32'hFFFFF, 6'd20, 1'b0);
      send(32'h12345, 6'd20, 1'b0);
      drain("spill");
      pop_got("spill", 32'hFFFFF123, 6'd32);
      do_flush();
      drain("spill_rem");
      pop_got("spill_rem", 32'h45000000, 6'd8);

      // Zero length, clamped lengths and ignored upper bits.
      send(32'hFFFFFFFF, 6'd0, 1'b0);
      send(32'hDEADBEEF, 6'd40, 1'b0);
      drain("clamp40");
      pop_got("clamp40", 32'hDEADBEEF, 6'd32);
      send(32'hCAFEF00D, 6'd63, 1'b0);
      drain("clamp63");
      pop_got("clamp63", 32'hCAFEF00D, 6'd32);
      send(32'hFFFFFFF5, 6'd4, 1'b0);
      do_flush();
      drain("masked");
      pop_got("masked", 32'h50000000, 6'd4);

      // Flush in the same cycle as a word-completing accept.
      send(32'h1234567, 6'd28, 1'b0);
      send(32'hABC, 6'd12, 1'b1);
      drain("flush_accept");
      pop_got("flush_accept_word", 32'h1234567A, 6'd32);
      pop_got("flush_accept_rem", 32'hBC000000, 6'd8);

      // Backpressure on the output.
      bus.out_ready = 1'b0;
      send(32'h11, 6'd8, 1'b0);
      send(32'h22, 6'd8, 1'b0);
      send(32'h33, 6'd8, 1'b0);
      send(32'h44, 6'd8, 1'b0);
      repeat (5) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
         chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
      chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
      pop_got("bp", 32'h11223344, 6'd32);
      chk("bp_single_word", 64'(got_q.size()), 64'd0);
      @(posedge clk);
      #1;

      // Asynchronous reset with 24 bits buffered.
      send(32'h55, 6'd8, 1'b0);
      send(32'h66, 6'd8, 1'b0);
      send(32'h77, 6'd8, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_rst_out_data",  64'(bus.out_data),  64'd0);
      chk("mid_rst_out_fill",  64'(bus.out_fill),  64'd0);
      chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
      #1 rst_n = 1'b1;
      idle(1);
      send(32'h01, 6'd8, 1'b0);
      send(32'h02, 6'd8, 1'b0);
      send(32'h03, 6'd8, 1'b0);
      send(32'h04, 6'd8, 1'b0);
      drain("after_rst");
      pop_got("after_rst", 32'h01020304, 6'd32);
      chk("after_rst_words", 64'(got_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
